// File: rtl/gs_mem_resp_if.sv
// GS byte-port / external word-port bundle for gs_mem_resp.
// The slave modport is the responder's view; master is the GS core plus memory side.
interface gs_mem_resp_if #(
  parameter int ADDR_W = 21
);
  // GS byte-wide side
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              rd;
  logic              wr;
  logic              ready;
  // 16-bit req/ack memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  addr, din, rd, wr, mem_rdata, mem_ack,
    output dout, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output addr, din, rd, wr, mem_rdata, mem_ack,
    input  dout, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/gs_mem_resp.sv
// General Sound memory responder: converts level-held GS byte reads/writes
// into 16-bit req/ack word transactions, with a one-word write-through read
// cache so sequential byte fetches from the same word avoid a round-trip.
module gs_mem_resp #(
  parameter int ADDR_W = 21
) (
  input  logic          clk_sys,
  input  logic          reset,
  gs_mem_resp_if.slave  bus
);

  localparam int WA_W = ADDR_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIT,
    S_RD,
    S_WR
  } state_t;

  state_t state_q, state_d;

  logic            ready_q,     ready_d;
  logic [7:0]      dout_q,      dout_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [WA_W-1:0] mem_addr_q,  mem_addr_d;
  logic [1:0]      mem_be_q,    mem_be_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [WA_W-1:0] tag_q,       tag_d;
  logic [15:0]     cdata_q,     cdata_d;
  logic            cvalid_q,    cvalid_d;
  logic            served_q,    served_d;
  logic            lane_q,      lane_d;

  logic [WA_W-1:0] req_word;
  logic            req_hit;
  logic            wr_hit;

  assign req_word = bus.addr[ADDR_W-1:1];
  assign req_hit  = cvalid_q && (tag_q == req_word);
  // A write in flight targets mem_addr_q; refresh the cache only if it holds that word.
  assign wr_hit   = cvalid_q && (tag_q == mem_addr_q);

  // Next-state and next-register values for the request FSM.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    dout_d      = dout_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = tag_q;
    cdata_d     = cdata_q;
    cvalid_d    = cvalid_q;
    served_d    = served_q;
    lane_d      = lane_q;

    // The GS dropping both strobes re-arms acceptance; completion below overrides.
    if (!bus.rd && !bus.wr) begin
      served_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if ((bus.rd || bus.wr) && !served_q) begin
          ready_d = 1'b0;
          lane_d  = bus.addr[0];
          if (bus.wr) begin
            state_d     = S_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_word;
            mem_be_d    = bus.addr[0] ? 2'b10 : 2'b01;
            mem_wdata_d = {bus.din, bus.din};
          end else if (req_hit) begin
            state_d = S_HIT;
          end else begin
            state_d     = S_RD;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = req_word;
            mem_be_d    = 2'b11;
            mem_wdata_d = {bus.din, bus.din};
          end
        end
      end

      S_HIT: begin
        dout_d   = lane_q ? cdata_q[15:8] : cdata_q[7:0];
        ready_d  = 1'b1;
        served_d = 1'b1;
        state_d  = S_IDLE;
      end

      S_RD: begin
        if (bus.mem_ack) begin
          tag_d     = mem_addr_q;
          cdata_d   = bus.mem_rdata;
          cvalid_d  = 1'b1;
          dout_d    = lane_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          served_d  = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_WR: begin
        if (bus.mem_ack) begin
          if (wr_hit) begin
            if (lane_q) begin
              cdata_d[15:8] = mem_wdata_q[15:8];
            end else begin
              cdata_d[7:0] = mem_wdata_q[7:0];
            end
          end
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          served_d  = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, cache and handshake bookkeeping; reset invalidates the cache.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      dout_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      cdata_q     <= '0;
      cvalid_q    <= 1'b0;
      served_q    <= 1'b0;
      lane_q      <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      dout_q      <= dout_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      cdata_q     <= cdata_d;
      cvalid_q    <= cvalid_d;
      served_q    <= served_d;
      lane_q      <= lane_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.dout      = dout_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_gs_mem_resp.sv
// Self-checking bench for gs_mem_resp: directed vector table, hand sequences
// for reset/long-wait/spurious-ack, and random traffic against a reference
// model (memory contents + which word the cache should hold).
module tb_gs_mem_resp;

  localparam int AW = 21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gs_mem_resp_if #(.ADDR_W(AW)) bus ();

  gs_mem_resp #(.ADDR_W(AW)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // External memory as seen by the DUT, and the reference contents.
  logic [15:0] ext_mem [int];
  logic [15:0] ref_mem [int];
  bit          ref_valid;
  logic [19:0] ref_tag;

  typedef struct {
    int          waits;
    int          n_req;
    logic        we;
    logic [1:0]  be;
    logic [19:0] maddr;
    logic [15:0] wdata;
    logic [7:0]  dout;
    bit          stable;
    bit          timeout;
    int          hold_bad;
  } obs_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [7:0]  din;
    int          dly;
    int          hold;
    bit          exp_txn;
    logic        exp_we;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_dout;
  } vec_t;

  function automatic logic [15:0] init_word(int w);
    return 16'(w * 40503) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ext_rd(int w);
    if (ext_mem.exists(w)) return ext_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [15:0] ref_rd(int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference prediction straight from the rules: writes always go out,
  // reads go out unless the cache holds that word; data comes from memory.
  task automatic predict(input logic r, input logic w, input logic [20:0] a,
                         input logic [7:0] d, input int dly, input int hold, output vec_t v);
    logic [15:0] word;
    word        = ref_rd(int'(a[20:1]));
    v.rd        = r;
    v.wr        = w;
    v.addr      = a;
    v.din       = d;
    v.dly       = dly;
    v.hold      = hold;
    v.exp_txn   = w || !(ref_valid && ref_tag == a[20:1]);
    v.exp_we    = w;
    v.exp_be    = w ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    v.exp_wdata = {d, d};
    v.exp_dout  = a[0] ? word[15:8] : word[7:0];
  endtask

  task automatic model_commit(input logic w, input logic [20:0] a, input logic [7:0] d);
    logic [15:0] word;
    if (w) begin
      word = ref_rd(int'(a[20:1]));
      if (a[0]) word[15:8] = d;
      else      word[7:0]  = d;
      ref_mem[int'(a[20:1])] = word;
    end else if (!(ref_valid && ref_tag == a[20:1])) begin
      ref_valid = 1'b1;
      ref_tag   = a[20:1];
    end
  endtask

  // One GS access with the memory responder acking `dly` cycles after mem_req is seen.
  task automatic access(input vec_t v, output obs_t o);
    int          k;
    bit          prev_req, seen_low, done;
    logic [15:0] word;
    o = '{default: 0};
    @(negedge clk);
    bus.addr = v.addr;
    bus.din  = v.din;
    bus.rd   = v.rd;
    bus.wr   = v.wr;
    k = 0; prev_req = 1'b0; seen_low = 1'b0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (!prev_req) begin
          o.n_req++;
          o.we = bus.mem_we; o.be = bus.mem_be; o.maddr = bus.mem_addr;
          o.wdata = bus.mem_wdata; o.stable = 1'b1; k = 0;
        end else if (bus.mem_addr !== o.maddr || bus.mem_be !== o.be || bus.mem_we !== o.we) begin
          o.stable = 1'b0;
        end
        k++;
        if (k == v.dly) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            word = ext_rd(int'(bus.mem_addr));
            if (bus.mem_be[0]) word[7:0]  = bus.mem_wdata[7:0];
            if (bus.mem_be[1]) word[15:8] = bus.mem_wdata[15:8];
            ext_mem[int'(bus.mem_addr)] = word;
            bus.mem_rdata = 16'hDEAD;
          end else begin
            bus.mem_rdata = ext_rd(int'(bus.mem_addr));
          end
        end
      end
      prev_req = bus.mem_req;
      if (!bus.ready) begin
        seen_low = 1'b1;
        o.waits++;
      end else if (seen_low) begin
        done = 1'b1;
      end
    end
    o.timeout = !done;
    o.dout    = bus.dout;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (bus.mem_req) o.n_req++;
      if (!bus.ready)  o.hold_bad++;
    end
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    check({tag, " timeout"}, o.timeout, 1'b0);
    check({tag, " n_req"}, o.n_req, v.exp_txn ? 1 : 0);
    check({tag, " wait_cycles"}, o.waits, v.exp_txn ? v.dly : 1);
    if (v.exp_txn) begin
      check({tag, " mem_addr"}, o.maddr, v.addr[20:1]);
      check({tag, " mem_we"}, o.we, v.exp_we);
      check({tag, " mem_be"}, o.be, v.exp_be);
      check({tag, " mem_stable"}, o.stable, 1'b1);
      if (v.exp_we) check({tag, " mem_wdata"}, o.wdata, v.exp_wdata);
    end
    if (v.rd && !v.wr) check({tag, " dout"}, o.dout, v.exp_dout);
    if (v.hold > 0) check({tag, " hold_quiet"}, o.hold_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [8];
    vec_t        v;
    obs_t        o;
    logic [7:0]  dout_before;
    bit          got_req;
    int          kind;
    logic [20:0] a;

    ext_mem[8] = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    ref_valid  = 1'b0;
    ref_tag    = '0;

    //           rd    wr    addr        din    dly hold txn we    be     wdata     dout
    tbl[0] = '{1'b1, 1'b0, 21'h00010, 8'h00, 3, 0,  1, 1'b0, 2'b11, 16'h0000, 8'hEF};
    tbl[1] = '{1'b1, 1'b0, 21'h00011, 8'h00, 1, 0,  0, 1'b0, 2'b11, 16'h0000, 8'hBE};
    tbl[2] = '{1'b0, 1'b1, 21'h00011, 8'h5A, 2, 0,  1, 1'b1, 2'b10, 16'h5A5A, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 21'h00011, 8'h00, 1, 0,  0, 1'b0, 2'b11, 16'h0000, 8'h5A};
    tbl[4] = '{1'b1, 1'b0, 21'h00010, 8'h00, 1, 0,  0, 1'b0, 2'b11, 16'h0000, 8'hEF};
    tbl[5] = '{1'b1, 1'b1, 21'h00100, 8'h33, 1, 10, 1, 1'b1, 2'b01, 16'h3333, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 21'h00100, 8'h00, 2, 0,  1, 1'b0, 2'b11, 16'h0000, 8'h33};
    tbl[7] = '{1'b1, 1'b0, 21'h00011, 8'h00, 4, 0,  1, 1'b0, 2'b11, 16'h0000, 8'h5A};

    rst = 1'b1;
    bus.addr = '0; bus.din = '0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst ready", bus.ready, 1'b1);
    check("rst dout", bus.dout, 8'h00);
    check("rst mem_req", bus.mem_req, 1'b0);
    check("rst mem_we", bus.mem_we, 1'b0);
    check("rst mem_addr", bus.mem_addr, 20'h0);
    check("rst mem_be", bus.mem_be, 2'b00);
    check("rst mem_wdata", bus.mem_wdata, 16'h0);

    foreach (tbl[i]) begin
      access(tbl[i], o);
      check_txn($sformatf("vec%0d", i), tbl[i], o);
      model_commit(tbl[i].wr, tbl[i].addr, tbl[i].din);
    end

    // Reset while a read miss is waiting for its ack.
    @(negedge clk);
    bus.addr = 21'h00200; bus.rd = 1'b1;
    got_req = 1'b0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(negedge clk);
      got_req = bus.mem_req;
    end
    check("abort mem_req_rise", got_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort mem_req_drop", bus.mem_req, 1'b0);
    check("abort ready", bus.ready, 1'b1);
    bus.rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_valid = 1'b0;
    predict(1'b1, 1'b0, 21'h00010, 8'h00, 2, 0, v);
    check("after_abort expect_miss", v.exp_txn, 1'b1);
    access(v, o);
    check_txn("after_abort", v, o);
    model_commit(1'b0, v.addr, v.din);

    // Long ack delay, then a spurious ack while idle.
    predict(1'b1, 1'b0, 21'h00300, 8'h00, 100, 0, v);
    access(v, o);
    check_txn("slow_ack", v, o);
    model_commit(1'b0, v.addr, v.din);
    dout_before = bus.dout;
    @(negedge clk);
    bus.mem_rdata = 16'hFFFF;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    check("spurious ready", bus.ready, 1'b1);
    check("spurious mem_req", bus.mem_req, 1'b0);
    check("spurious dout", bus.dout, dout_before);
    predict(1'b1, 1'b0, 21'h00301, 8'h00, 1, 0, v);
    access(v, o);
    check_txn("spurious_hit", v, o);
    model_commit(1'b0, v.addr, v.din);

    // Random traffic over a small window so hits, misses and write-through all occur.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      a = 21'h00400 + 21'($urandom_range(0, 15));
      predict(kind < 6 || kind == 9, kind >= 6, a, 8'($urandom_range(0, 255)),
              $urandom_range(1, 4), $urandom_range(0, 2), v);
      access(v, o);
      check_txn($sformatf("rand%0d", n), v, o);
      model_commit(v.wr, v.addr, v.din);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
